serial_tx_fifo: RTL

Byte FIFO between a byte producer (serial receiver or echo/modify logic) and the tx_serial transmitter. Absorbs bursts of single-cycle byte strobes, then hands bytes to tx_serial one at a time using its send pulse and busy level. Lets received bytes arrive back-to-back while the transmitter is still shifting, with no bytes lost until the FIFO is full. Runs entirely in the PLL clock domain, the same clock as serial and tx_serial.

---
 rtl/serial_tx_fifo_if.sv | 38 +++
 rtl/serial_tx_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo_if.sv
// Byte-producer / transmitter handshake bundle for serial_tx_fifo.
// The ovf/drop_cnt signals exist only when SERIAL_TX_FIFO_OVF_EN is defined.
interface serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_byte;
    logic                wr_en;
    logic [7:0]          sbyte;
    logic                send;
    logic                busy;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
`ifdef SERIAL_TX_FIFO_OVF_EN
    logic                ovf;
    logic [7:0]          drop_cnt;

    modport master (
        output wr_byte, wr_en, busy,
        input  sbyte, send, full, empty, level, ovf, drop_cnt
    );

    modport slave (
        input  wr_byte, wr_en, busy,
        output sbyte, send, full, empty, level, ovf, drop_cnt
    );
`else
    modport master (
        output wr_byte, wr_en, busy,
        input  sbyte, send, full, empty, level
    );

    modport slave (
        input  wr_byte, wr_en, busy,
        output sbyte, send, full, empty, level
    );
`endif
endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding tx_serial one byte at a time via send pulse / busy level.
// Optional overflow flag and drop counter under SERIAL_TX_FIFO_OVF_EN.
//
// state   | meaning
// IDLE    | wait for data and an idle transmitter
// LOAD    | latch head byte into sbyte, pop
// SEND    | one-cycle send pulse
// WAIT_HI | wait for busy to rise (bounded by BUSY_WAIT)
// WAIT_LO | wait for busy to fall
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic           clk100,
    input  logic           reset,
    serial_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = LVL_ONE[DEPTH_LOG2-1:0];
    localparam logic [7:0]            WAIT_INIT = 8'(BUSY_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic [7:0]            r_sbyte;
    logic [7:0]            r_wait_cnt;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_send;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    // full is the registered flag, so a write racing a pop on a full FIFO is dropped
    assign w_push = bus.wr_en & ~r_full;
    assign w_pop  = (r_state == ST_LOAD);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk100) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_byte;
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_sbyte  <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_sbyte  <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Timeout budget is armed entering SEND, so the send cycle counts toward BUSY_WAIT
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_LOAD) begin
            r_wait_cnt <= WAIT_INIT;
        end else if ((r_state == ST_SEND || r_state == ST_WAIT_HI) && r_wait_cnt != 8'd0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (!r_empty && !bus.busy) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_SEND;
            ST_SEND:    w_state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (bus.busy || r_wait_cnt <= 8'd1) w_state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!bus.busy) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_send = (r_state == ST_SEND);
    end

    assign bus.send  = w_send;
    assign bus.sbyte = r_sbyte;
    assign bus.full  = r_full;
    assign bus.empty = r_empty;
    assign bus.level = r_level;

`ifdef SERIAL_TX_FIFO_OVF_EN
    logic       r_ovf;
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else if (bus.wr_en && r_full) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.ovf      = r_ovf;
    assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule
